alu181_seq_ctrl: RTL and testbench
==================================

Name: alu181_seq_ctrl

Overview:
Multi-cycle sequencer that performs a WIDTH = 4*NIBBLES bit operation by driving one external 4-bit jeff_74x181 slice, one nibble per clock, LSB first. The carry is chained between nibbles through a register. It latches the operands and opcode on start, drives the slice's S/M/Cn/A/B pins, and collects the F and Cn+4 outputs. It then presents the result with a one-cycle done pulse. It sits between a simple command source and the slice.

Parameters:
NIBBLES, 4, number of 4-bit slices processed per operation (>=2); WIDTH = 4*NIBBLES.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  command strobe; sampled only in IDLE or DONE
op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 INC A, 111 PASS B
a  input  WIDTH  operand A; latched on an accepted start
b  input  WIDTH  operand B; latched on an accepted start
busy  output  1  high while nibbles are being processed
done  output  1  one-cycle pulse when the result is valid
result  output  WIDTH  registered result; holds until the next done
carry_out  output  1  active-high final carry (SUB: 1 = no borrow); 0 for logic ops
zero  output  1  result == 0; registered with result
alu_a  output  4  to slice A3..A0
alu_b  output  4  to slice B3..B0
alu_s  output  4  to slice S3..S0
alu_m  output  1  to slice M
alu_ci  output  1  to slice Cn (active-low carry, active-high data convention)
alu_f  input  4  from slice F3..F0
alu_co  input  1  from slice Cn+4 (active-low carry)

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE; busy=0, done=0, result=0, carry_out=0, zero=0.
  - Internal shift/carry/index registers are cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches a, b, op; clears the index; goes to RUN.
  - RUN: lasts exactly NIBBLES cycles; after the last nibble is captured, goes to DONE.
  - DONE: done=1 for that single cycle. start=1 is accepted exactly as in IDLE (back-to-back operation, goes to RUN); otherwise goes to IDLE.
  - start during RUN is ignored; the latched operands are not disturbed.
- Timing, with start sampled at edge E:
  - busy=1 after edges E..E+N-1.
  - Nibble i is driven to the slice in the cycle after edge E+i.
  - alu_f and alu_co are captured at edge E+i+1.
  - result, carry_out and zero load at edge E+N, together with done=1.
  - Latency is N cycles; throughput is one operation per N cycles.
- Slice drive is combinational from registered state only; there is no combinational path from a, b, op or start.
  - In RUN, alu_a/alu_b = nibble i of the latched A/B.
  - Outside RUN: alu_a=0, alu_b=0, alu_s=0000, alu_m=1, alu_ci=1.
- Opcode to slice mapping (S, M, Cn for nibble 0):
  - ADD: 1001, 0, 1
  - SUB: 0110, 0, 0
  - INC: 0000, 0, 0
  - AND: 1011, 1
  - OR: 1110, 1
  - XOR: 0110, 1
  - NOT A: 0000, 1
  - PASS B: 1010, 1
  - Logic ops drive alu_ci=1.
- Carry chain:
  - For nibbles 1..N-1, alu_ci = registered alu_co from the previous nibble, for arithmetic ops only.
  - Final carry_out = ~alu_co of nibble N-1 for ADD/SUB/INC; 0 for logic ops.
- Result assembly:
  - An accumulator shifts right by 4 each RUN cycle, inserting alu_f at the top.
  - result is loaded from the accumulator at the DONE transition only. It never shows partial values.
- Arithmetic wraps modulo 2^WIDTH.

Test Plan:
- Bench setup: NIBBLES=4, jeff_74x181 slice connected to alu_* ports.
- ADD a=0x1234 b=0x0FCD, start at edge E -> busy high 4 cycles; done only in cycle after E+4; result=0x2201, carry_out=0, zero=0.
- ADD a=0xFFFF b=0x0001 -> result=0x0000, carry_out=1, zero=1; INC a=0x00FF -> result=0x0100, carry_out=0.
- SUB a=0x0005 b=0x0007 -> result=0xFFFE, carry_out=0; SUB a=0x1000 b=0x0001 -> result=0x0FFF, carry_out=1.
- Logic ops with a=0xF0F0 b=0x3C3C, carry_out=0 for all:
  - AND -> 0x3030
  - OR -> 0xFCFC
  - XOR -> 0xCCCC
  - NOT A -> 0x0F0F
  - PASS B -> 0x3C3C
- During ADD 0x0001+0x0001, pulse start with a=0xAAAA in RUN cycle 2 -> ignored; result=0x0002. start held in the DONE cycle with SUB 0x0010-0x0001 -> accepted with no IDLE gap; result=0x000F four cycles later.
- rst_n=0 in RUN cycle 2 -> next cycle busy=0, done=0, result=0, alu_m=1, alu_ci=1; no done pulse afterwards; a new start after reset completes normally.

Source files
------------

// File: rtl/alu181_seq_ctrl.sv
//------------------------------------------------------------------------------
// alu181_seq_ctrl : nibble-serial sequencer driving one external 74x181 slice
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu181_seq_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_ci,
    input  logic [3:0]       alu_f,
    input  logic             alu_co
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [2:0] C_OP_ADD  = 3'b000;
    localparam logic [2:0] C_OP_SUB  = 3'b001;
    localparam logic [2:0] C_OP_AND  = 3'b010;
    localparam logic [2:0] C_OP_OR   = 3'b011;
    localparam logic [2:0] C_OP_XOR  = 3'b100;
    localparam logic [2:0] C_OP_NOTA = 3'b101;
    localparam logic [2:0] C_OP_INC  = 3'b110;
    localparam logic [2:0] C_OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               zero_q, zero_d;

    logic               w_is_arith;
    logic               w_cn0;

    assign w_is_arith = (op_q == C_OP_ADD) || (op_q == C_OP_SUB) || (op_q == C_OP_INC);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        zero_d      = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Slice output enters at the top so nibble 0 ends up at the bottom.
                acc_d   = {alu_f, acc_q[WIDTH-1:4]};
                carry_d = alu_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d     = S_DONE;
                    result_d    = acc_d;
                    carry_out_d = w_is_arith ? ~alu_co : 1'b0;
                    zero_d      = (acc_d == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alu_a  = 4'h0;
        alu_b  = 4'h0;
        alu_s  = 4'b0000;
        alu_m  = 1'b1;
        alu_ci = 1'b1;
        w_cn0  = 1'b1;
        if (state_q == S_RUN) begin
            alu_a = a_q[{idx_q, 2'b00} +: 4];
            alu_b = b_q[{idx_q, 2'b00} +: 4];
            case (op_q)
                C_OP_ADD:  begin alu_s = 4'b1001; alu_m = 1'b0; w_cn0 = 1'b1; end
                C_OP_SUB:  begin alu_s = 4'b0110; alu_m = 1'b0; w_cn0 = 1'b0; end
                C_OP_INC:  begin alu_s = 4'b0000; alu_m = 1'b0; w_cn0 = 1'b0; end
                C_OP_AND:  alu_s = 4'b1011;
                C_OP_OR:   alu_s = 4'b1110;
                C_OP_XOR:  alu_s = 4'b0110;
                C_OP_NOTA: alu_s = 4'b0000;
                C_OP_PASS: alu_s = 4'b1010;
                default:   alu_s = 4'b0000;
            endcase
            if (idx_q == '0)
                alu_ci = w_cn0;
            else
                alu_ci = w_is_arith ? carry_q : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu181_seq_ctrl.sv
//------------------------------------------------------------------------------
// tb_alu181_seq_ctrl : vector table plus corner-case sequences, 74x181 modelled
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu181_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [3:0]   alu_s;
    logic         alu_m;
    logic         alu_ci;
    logic [3:0]   alu_f;
    logic         alu_co;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu181_seq_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_ci(alu_ci),
        .alu_f(alu_f), .alu_co(alu_co)
    );

    // 74x181 slice, active-high data, active-low carry in/out
    logic [4:0] sum;
    always_comb begin
        sum = {1'b0, alu_a} + {4'b0, ~alu_ci};
        case (alu_s)
            4'b0110: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, ~alu_ci};
            4'b1001: sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, ~alu_ci};
            default: sum = {1'b0, alu_a} + {4'b0, ~alu_ci};
        endcase
        alu_f  = sum[3:0];
        alu_co = ~sum[4];
        if (alu_m) begin
            alu_co = 1'b1;
            case (alu_s)
                4'b0000: alu_f = ~alu_a;
                4'b0001: alu_f = ~(alu_a | alu_b);
                4'b0010: alu_f = ~alu_a & alu_b;
                4'b0011: alu_f = 4'h0;
                4'b0100: alu_f = ~(alu_a & alu_b);
                4'b0101: alu_f = ~alu_b;
                4'b0110: alu_f = alu_a ^ alu_b;
                4'b0111: alu_f = alu_a & ~alu_b;
                4'b1000: alu_f = ~alu_a | alu_b;
                4'b1001: alu_f = ~(alu_a ^ alu_b);
                4'b1010: alu_f = alu_b;
                4'b1011: alu_f = alu_a & alu_b;
                4'b1100: alu_f = 4'hF;
                4'b1101: alu_f = alu_a | ~alu_b;
                4'b1110: alu_f = alu_a | alu_b;
                default: alu_f = alu_a;
            endcase
        end
    end

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         co;
        logic         z;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("busy_run", {31'b0, busy}, 32'd1);
            chk("done_run", {31'b0, done}, 32'd0);
            chk("alu_a_nib", {28'b0, alu_a}, {28'b0, v.a[4*i +: 4]});
        end
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("busy_done", {31'b0, busy}, 32'd0);
        chk("result", {16'b0, result}, {16'b0, v.r});
        chk("carry_out", {31'b0, carry_out}, {31'b0, v.co});
        chk("zero", {31'b0, zero}, {31'b0, v.z});
    endtask

    initial begin
        vecs[0]  = '{3'b000, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0};
        vecs[1]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[2]  = '{3'b110, 16'h00FF, 16'h5A5A, 16'h0100, 1'b0, 1'b0};
        vecs[3]  = '{3'b001, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0};
        vecs[5]  = '{3'b010, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
        vecs[6]  = '{3'b011, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 1'b0};
        vecs[8]  = '{3'b101, 16'hF0F0, 16'h3C3C, 16'h0F0F, 1'b0, 1'b0};
        vecs[9]  = '{3'b111, 16'hF0F0, 16'h3C3C, 16'h3C3C, 1'b0, 1'b0};
        vecs[10] = '{3'b100, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'd0);
        chk("rst_carry", {31'b0, carry_out}, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_alu_m", {31'b0, alu_m}, 32'd1);
        chk("rst_alu_ci", {31'b0, alu_ci}, 32'd1);
        chk("rst_alu_s", {28'b0, alu_s}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // start during RUN ignored, then back-to-back start from DONE
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 16'h0001; b = 16'h0001;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 16'hAAAA;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("ign_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("ign_done", {31'b0, done}, 32'd1);
        chk("ign_result", {16'b0, result}, 32'h0002);
        start = 1'b1; op = 3'b001; a = 16'h0010; b = 16'h0001;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_hold", {16'b0, result}, 32'h0002);
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("b2b_done", {31'b0, done}, 32'd1);
        chk("b2b_result", {16'b0, result}, 32'h000F);
        chk("b2b_carry", {31'b0, carry_out}, 32'd1);

        // reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 16'h1234; b = 16'h0FCD;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", {16'b0, result}, 32'd0);
        chk("abort_alu_m", {31'b0, alu_m}, 32'd1);
        chk("abort_alu_ci", {31'b0, alu_ci}, 32'd1);
        begin
            logic seen;
            seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            chk("abort_no_done", {31'b0, seen}, 32'd0);
        end
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
